// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
//   Scan controller for a 4-digit seven-segment display. A prescaler produces
//   one tick every REFRESH_DIV clocks. Each tick advances a one-hot ring over
//   the four digits. The displayed value sits in a shadow register. The shadow
//   register commits val_in only at a frame boundary (a tick while digit 3 is
//   selected), so one frame never mixes old and new digits.
//
//   Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero digits.
//   When it is defined, digit 0 is always shown. When it is not defined, every
//   enabled digit is lit.
//
// Ports
//   clk, rst_n    clock (rising edge) and async active-low reset
//   val_in[15:0]  value to display; nibble [3:0] is the rightmost digit
//   load          level request to commit val_in at the next frame boundary
//   load_ack      1-cycle pulse: val_in captured into the shadow register
//   dig_en[3:0]   per-digit enable; 0 forces that anode off
//   sel[3:0]      registered one-hot digit select, active-high
//   an[3:0]       anode enables, active-low
//   hex[3:0]      shadow nibble of the currently selected digit
//   frame_start   1-cycle pulse when sel returns to 4'b0001
module digit_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val_in,
  input  logic        load,
  output logic        load_ack,
  input  logic [3:0]  dig_en,
  output logic [3:0]  sel,
  output logic [3:0]  an,
  output logic [3:0]  hex,
  output logic        frame_start
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        sel_q, sel_d;
  logic [15:0]       shadow_q, shadow_d;
  logic              load_ack_q, load_ack_d;
  logic              frame_start_q, frame_start_d;
  logic              tick, boundary;
  logic [3:0]        blank;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (state_q == S3);

  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    state_d       = state_q;
    if (tick) begin
      unique case (state_q)
        S0: state_d = S1;
        S1: state_d = S2;
        S2: state_d = S3;
        S3: state_d = S0;
      endcase
    end
    // sel is registered together with the state, so it never glitches.
    unique case (state_d)
      S0: sel_d = 4'b0001;
      S1: sel_d = 4'b0010;
      S2: sel_d = 4'b0100;
      S3: sel_d = 4'b1000;
    endcase
    // The commit happens on the same edge as the wrap to S0, so the new
    // frame shows the new value starting from digit 0.
    shadow_d      = (boundary && load) ? val_in : shadow_q;
    load_ack_d    = boundary && load;
    frame_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S0;
      cnt_q         <= '0;
      sel_q         <= 4'b0001;
      shadow_q      <= 16'h0000;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero.
  // Digit 0 always stays lit, so a zero value still shows "0".
  always_comb begin
    blank[3] = ~|shadow_q[15:12];
    blank[2] = ~|shadow_q[15:8];
    blank[1] = ~|shadow_q[15:4];
    blank[0] = 1'b0;
  end
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    unique case (sel_q)
      4'b0010: hex = shadow_q[7:4];
      4'b0100: hex = shadow_q[11:8];
      4'b1000: hex = shadow_q[15:12];
      default: hex = shadow_q[3:0];
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_an
    assign an[i] = ~(sel_q[i] & dig_en[i] & ~blank[i]);
  end

  assign sel         = sel_q;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl with REFRESH_DIV=4. The stimulus pushes
// the expected outputs for specific cycles after reset release. A monitor
// pops each entry at the negedge of that cycle and compares it with the DUT.
module tb_digit_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] val_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  dig_en;
  logic [3:0]  sel, an, hex;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int         cyc;
    logic [3:0] sel;
    logic [3:0] an;
    logic [3:0] hex;
    logic       ack;
    logic       fs;
  } exp_t;

  exp_t q[$];

  digit_scan_ctrl #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .val_in(val_in), .load(load), .load_ack(load_ack),
    .dig_en(dig_en), .sel(sel), .an(an), .hex(hex), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic logic [3:0] blank_of(logic [15:0] s);
    logic [3:0] b;
    b = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    b[3] = (s[15:12] == 4'h0);
    b[2] = (s[15:8]  == 8'h00);
    b[1] = (s[15:4]  == 12'h000);
`endif
    return b;
  endfunction

  // The digit slot after k edges is (k/4)%4, because each slot lasts 4 clocks.
  function automatic void push(int k, logic [15:0] sh, logic [3:0] den, logic ack, logic fs);
    exp_t e;
    int   slot;
    slot  = (k / 4) % 4;
    e.cyc = k;
    e.sel = 4'(1 << slot);
    e.hex = sh[slot*4 +: 4];
    e.an  = ~(e.sel & den & ~blank_of(sh));
    e.ack = ack;
    e.fs  = fs;
    q.push_back(e);
  endfunction

  // No load commits in this range, so frame_start pulses only at multiples of 16.
  function automatic void push_range(int a, int b, logic [15:0] sh, logic [3:0] den);
    for (int k = a; k <= b; k++) push(k, sh, den, 1'b0, (k % 16) == 0);
  endfunction

  function automatic void chk(string nm, int k, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, k, act, exp);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_entry cyc=%0d now=%0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("sel", cyc, sel, e.sel);
        chk("an", cyc, an, e.an);
        chk("hex", cyc, hex, e.hex);
        chk("load_ack", cyc, {3'b0, load_ack}, {3'b0, e.ack});
        chk("frame_start", cyc, {3'b0, frame_start}, {3'b0, e.fs});
      end
    end
  end

  initial begin
    load   = 1'b0;
    dig_en = 4'hF;
    val_in = 16'h0000;
    // Reset is checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sel", 0, sel, 4'b0001);
    chk("rst_an", 0, an, 4'b1110);
    chk("rst_hex", 0, hex, 4'h0);
    chk("rst_ack", 0, {3'b0, load_ack}, 4'h0);
    chk("rst_fs", 0, {3'b0, frame_start}, 4'h0);

    // Scan, then a load request at clk 5 that commits at the clk-16 boundary.
    @(negedge clk) rst_n = 1'b1;
    push_range(1, 15, 16'h0000, 4'hF);
    push(16, 16'hA5C3, 4'hF, 1'b1, 1'b1);
    push_range(17, 32, 16'hA5C3, 4'hF);
    repeat (5) @(negedge clk);
    val_in = 16'hA5C3;
    load   = 1'b1;
    repeat (11) @(negedge clk);
    load = 1'b0;                          // cyc 16: drop after ack
    repeat (17) @(negedge clk);

    // cyc 33: partial digit enables.
    dig_en = 4'b0101;
    push_range(34, 47, 16'hA5C3, 4'b0101);
    repeat (15) @(negedge clk);

    // cyc 48: load 0000 and keep load high. After the ack, load 0007 as a
    // back-to-back second request.
    dig_en = 4'hF;
    val_in = 16'h0000;
    load   = 1'b1;
    push_range(49, 63, 16'hA5C3, 4'hF);
    push(64, 16'h0000, 4'hF, 1'b1, 1'b1);
    push_range(65, 79, 16'h0000, 4'hF);
    push(80, 16'h0007, 4'hF, 1'b1, 1'b1);
    push_range(81, 104, 16'h0007, 4'hF);
    repeat (16) @(negedge clk);
    val_in = 16'h0007;                    // cyc 64
    repeat (16) @(negedge clk);
    load = 1'b0;                          // cyc 80
    repeat (25) @(negedge clk);

    // cyc 105 (S2): a load is pending and reset is pulsed mid-frame.
    val_in = 16'h1234;
    load   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", cyc, sel, 4'b0001);
    chk("mid_rst_an", cyc, an, 4'b1110);
    chk("mid_rst_hex", cyc, hex, 4'h0);
    chk("mid_rst_ack", cyc, {3'b0, load_ack}, 4'h0);
    chk("mid_rst_fs", cyc, {3'b0, frame_start}, 4'h0);
    @(negedge clk) rst_n = 1'b1;          // retry: load stays high
    push_range(1, 15, 16'h0000, 4'hF);
    push(16, 16'h1234, 4'hF, 1'b1, 1'b1);
    push_range(17, 20, 16'h1234, 4'hF);
    repeat (16) @(negedge clk);
    load = 1'b0;

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
